// File: rtl/shift_pkg.sv
// Shared encodings for the operand-2 shift sequencer.
package shift_pkg;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} sh_type_e;
  typedef enum logic [1:0] {KIND_IMM, KIND_REG, KIND_ROT, KIND_BR} kind_e;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
endpackage

// File: rtl/shift_step.sv
// One bounded shift step (0..STEP_MAX positions) with the last bit shifted out as carry.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STEP_MAX = 8,
  localparam int AW      = $clog2(STEP_MAX) + 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  sh_type_e          type_i,
  input  logic [AW-1:0]     amt_i,
  input  logic              sign_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] data_o,
  output logic              carry_o
);
  logic [DATA_W:0]   ext_l, ext_r;
  logic [DATA_W-1:0] fill, rot;

  // Extra bit below/above the word captures the last bit shifted out.
  assign ext_l = {1'b0, data_i} << amt_i;
  assign ext_r = {data_i, 1'b0} >> amt_i;
  assign fill  = ~({DATA_W{1'b1}} >> amt_i);
  assign rot   = (data_i >> amt_i) | (data_i << (DATA_W - int'(amt_i)));

  always_comb begin
    data_o  = data_i;
    carry_o = carry_i;
    if (amt_i != '0) begin
      case (type_i)
        SH_LSL: begin data_o = ext_l[DATA_W-1:0]; carry_o = ext_l[DATA_W]; end
        SH_LSR: begin data_o = ext_r[DATA_W:1];   carry_o = ext_r[0];      end
        SH_ASR: begin
          data_o  = ext_r[DATA_W:1] | (sign_i ? fill : '0);
          carry_o = ext_r[0];
        end
        SH_ROR: begin data_o = rot; carry_o = rot[DATA_W-1]; end
      endcase
    end
  end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle operand-2 shift controller: resolves ARM special encodings in LOAD,
// otherwise iterates a bounded step shifter until the requested amount is consumed.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STEP_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        shift_imm,
  input  logic [7:0]        rs_byte,
  input  logic [DATA_W-1:0] operand,
  input  logic              carry_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              busy
);
  localparam int AW = $clog2(STEP_MAX) + 1;

  state_e            state_q;
  kind_e             kind_q;
  sh_type_e          type_q, wtype_q;
  logic [4:0]        imm_q;
  logic [7:0]        rs_q;
  logic [DATA_W-1:0] op_q, work_q, result_q;
  logic              cin_q, wcarry_q, carry_q, rvld_q;
  logic [5:0]        rem_q, rem_d;

  logic              sp_hit, sp_c;
  logic [DATA_W-1:0] sp_res;
  logic [4:0]        ld_amt;
  sh_type_e          ld_type;
  logic [AW-1:0]     step_amt;
  logic [DATA_W-1:0] st_data;
  logic              st_c;

  // Special-case decode on the latched request; ld_* describe the iterative path.
  always_comb begin
    sp_hit  = 1'b0;
    sp_res  = op_q;
    sp_c    = cin_q;
    ld_amt  = imm_q;
    ld_type = type_q;
    case (kind_q)
      KIND_IMM: if (imm_q == 5'd0) begin
        sp_hit = 1'b1;
        case (type_q)
          SH_LSL: ;
          SH_LSR: begin sp_res = '0;                sp_c = op_q[31]; end
          SH_ASR: begin sp_res = {DATA_W{op_q[31]}}; sp_c = op_q[31]; end
          SH_ROR: begin sp_res = {cin_q, op_q[31:1]}; sp_c = op_q[0]; end
        endcase
      end
      KIND_REG: begin
        ld_amt = rs_q[4:0];
        if (rs_q == 8'd0) sp_hit = 1'b1;
        else begin
          case (type_q)
            SH_LSL: if (rs_q >= 8'd32) begin
              sp_hit = 1'b1; sp_res = '0; sp_c = (rs_q == 8'd32) ? op_q[0] : 1'b0;
            end
            SH_LSR: if (rs_q >= 8'd32) begin
              sp_hit = 1'b1; sp_res = '0; sp_c = (rs_q == 8'd32) ? op_q[31] : 1'b0;
            end
            SH_ASR: if (rs_q >= 8'd32) begin
              sp_hit = 1'b1; sp_res = {DATA_W{op_q[31]}}; sp_c = op_q[31];
            end
            SH_ROR: if (rs_q[4:0] == 5'd0) begin
              sp_hit = 1'b1; sp_c = op_q[31];
            end
          endcase
        end
      end
      KIND_ROT: begin
        ld_type = SH_ROR;
        if (imm_q == 5'd0) sp_hit = 1'b1;
      end
      KIND_BR: begin
        sp_hit = 1'b1;
        sp_res = {{6{op_q[23]}}, op_q[23:0], 2'b00};
      end
    endcase
  end

  always_comb begin
    step_amt = (rem_q > 6'(STEP_MAX)) ? AW'(STEP_MAX) : rem_q[AW-1:0];
    rem_d    = rem_q - 6'(step_amt);
  end

  shift_step #(.DATA_W(DATA_W), .STEP_MAX(STEP_MAX)) u_step (
    .data_i (work_q),
    .type_i (wtype_q),
    .amt_i  (step_amt),
    .sign_i (op_q[31]),
    .carry_i(wcarry_q),
    .data_o (st_data),
    .carry_o(st_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      rvld_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      rvld_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          kind_q  <= kind_e'(req_kind);
          type_q  <= sh_type_e'(shift_type);
          imm_q   <= shift_imm;
          rs_q    <= rs_byte;
          op_q    <= operand;
          cin_q   <= carry_in;
          state_q <= LOAD;
        end
        LOAD: if (sp_hit) begin
          result_q <= sp_res;
          carry_q  <= sp_c;
          rvld_q   <= 1'b1;
          state_q  <= DONE;
        end else begin
          work_q   <= op_q;
          wcarry_q <= cin_q;
          wtype_q  <= ld_type;
          rem_q    <= {1'b0, ld_amt};
          state_q  <= SHIFT;
        end
        SHIFT: begin
          work_q   <= st_data;
          wcarry_q <= st_c;
          rem_q    <= rem_d;
          if (rem_d == 6'd0) begin
            result_q <= st_data;
            carry_q  <= st_c;
            rvld_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: if (res_ready) begin
          rvld_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = reset & (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = rvld_q;
  assign result    = result_q;
  assign carry_out = carry_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an ARM barrel-shifter model.
module tb_shift_sequencer;
  localparam int STEP = 8;

  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic        req_valid = 1'b0, res_ready = 1'b0, carry_in = 1'b0;
  logic [1:0]  req_kind = '0, shift_type = '0;
  logic [4:0]  shift_imm = '0;
  logic [7:0]  rs_byte = '0;
  logic [31:0] operand = '0;
  logic        req_ready, res_valid, carry_out, busy;
  logic [31:0] result;

  int checks = 0, errors = 0;
  logic [31:0] last_r = '0;
  logic        last_c = 1'b0;

  shift_sequencer #(.DATA_W(32), .STEP_MAX(STEP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .shift_type(shift_type), .shift_imm(shift_imm),
    .rs_byte(rs_byte), .operand(operand), .carry_in(carry_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry_out(carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ARM shifter semantics with wide arithmetic; lat = accept-to-res_valid cycles.
  task automatic model(input logic [1:0] k, input logic [1:0] t, input logic [4:0] imm,
                       input logic [7:0] rs, input logic [31:0] op, input logic c,
                       output logic [31:0] r, output logic co, output int lat);
    int amt, it;
    logic [1:0] ty;
    logic [63:0] v;
    logic signed [23:0] off;
    int si;
    bit rrx;
    rrx = 0; amt = 0; it = 0; ty = t; r = op; co = c;
    case (k)
      2'd0: begin
        if (imm != 0) begin amt = imm; it = imm; end
        else if (t == 2'd3) rrx = 1;
        else if (t != 2'd0) amt = 32;
      end
      2'd1: begin
        amt = rs;
        if (t == 2'd3) it = rs % 32;
        else if (rs < 32) it = rs;
      end
      2'd2: begin ty = 2'd3; amt = imm; it = imm; end
      default: ;
    endcase
    if (k == 2'd3) begin
      off = op[23:0]; si = off; r = si * 4; co = c;
    end else if (rrx) begin
      r = {c, op[31:1]}; co = op[0];
    end else if (amt != 0) begin
      case (ty)
        2'd0: begin v = {32'b0, op} << amt; r = v[31:0];  co = v[32]; end
        2'd1: begin v = {op, 32'b0} >> amt; r = v[63:32]; co = v[31]; end
        2'd2: begin v = $signed({op, 32'b0}) >>> (amt > 32 ? 32 : amt); r = v[63:32]; co = v[31]; end
        default: begin
          if (amt % 32 == 0) begin r = op; co = op[31]; end
          else begin v = {op, op} >> (amt % 32); r = v[31:0]; co = r[31]; end
        end
      endcase
    end
    lat = (it == 0) ? 2 : 2 + (it + STEP - 1) / STEP;
  endtask

  task automatic run_op(input string tag, input logic [1:0] k, input logic [1:0] t,
                        input logic [4:0] imm, input logic [7:0] rs, input logic [31:0] op,
                        input logic c, input int hold);
    logic [31:0] er; logic ec; int el, lat, w;
    model(k, t, imm, rs, op, c, er, ec, el);
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_kind = k; shift_type = t; shift_imm = imm; rs_byte = rs; operand = op; carry_in = c;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (!res_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, result, er);
    chk({tag, " carry"}, 32'(carry_out), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold result"}, result, er);
      chk({tag, " hold valid"}, 32'(res_valid), 32'd1);
      chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, " released"}, 32'(res_valid), 32'd0);
    chk({tag, " idle"}, 32'(req_ready), 32'd1);
    last_r = er; last_c = ec;
  endtask

  initial begin
    logic [1:0] k, t;
    logic [4:0] imm;
    logic [7:0] rs;

    repeat (3) @(posedge clk);
    #1;
    chk("rst result", result, 32'd0);
    chk("rst carry", 32'(carry_out), 32'd0);
    chk("rst valid", 32'(res_valid), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    reset = 1'b1;
    #1;
    chk("post-rst req_ready", 32'(req_ready), 32'd1);

    run_op("imm lsl4", 2'd0, 2'd0, 5'd4, 8'd0, 32'h0000_00F1, 1'b0, 0);
    chk("imm lsl4 literal", result, 32'h0000_0F10);
    run_op("reg asr40", 2'd1, 2'd2, 5'd0, 8'd40, 32'h8000_0001, 1'b0, 0);
    chk("reg asr40 literal", result, 32'hFFFF_FFFF);
    run_op("rrx", 2'd0, 2'd3, 5'd0, 8'd0, 32'h0000_0003, 1'b1, 0);
    chk("rrx literal", result, 32'h8000_0001);
    run_op("reg lsr20", 2'd1, 2'd1, 5'd0, 8'd20, 32'hF000_0000, 1'b0, 1);
    chk("reg lsr20 literal", result, 32'h0000_0F00);
    run_op("branch", 2'd3, 2'd0, 5'd0, 8'd0, 32'h00FF_FFFE, 1'b0, 3);
    chk("branch literal", result, 32'hFFFF_FFF8);
    run_op("reg lsl32", 2'd1, 2'd0, 5'd0, 8'd32, 32'h0000_0001, 1'b0, 0);
    run_op("reg ror64", 2'd1, 2'd3, 5'd0, 8'd64, 32'h8000_0000, 1'b0, 0);
    run_op("rot imm", 2'd2, 2'd0, 5'd30, 8'd0, 32'h0000_00FF, 1'b0, 0);

    // Flush during the 2nd SHIFT cycle of reg ROR #31.
    req_kind = 2'd1; shift_type = 2'd3; rs_byte = 8'd31; operand = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush valid", 32'(res_valid), 32'd0);
    chk("flush req_ready", 32'(req_ready), 32'd1);
    chk("flush result kept", result, last_r);
    chk("flush carry kept", 32'(carry_out), 32'(last_c));
    run_op("after flush", 2'd0, 2'd1, 5'd9, 8'd0, 32'hDEAD_BEEF, 1'b1, 0);

    for (int n = 0; n < 80; n++) begin
      k = 2'($urandom_range(0, 3));
      t = 2'($urandom_range(0, 3));
      imm = 5'($urandom_range(0, 31));
      if (k == 2'd2) imm = imm & 5'h1E;
      case ($urandom_range(0, 4))
        0: rs = 8'd0;
        1: rs = 8'(32 * $urandom_range(1, 7));
        2: rs = 8'($urandom_range(33, 255));
        default: rs = 8'($urandom_range(1, 31));
      endcase
      run_op($sformatf("rand%0d", n), k, t, imm, rs, $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, 2));
    end

    // Reset mid-operation clears outputs as well as aborting.
    req_kind = 2'd1; shift_type = 2'd0; rs_byte = 8'd20; operand = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst result", result, 32'd0);
    chk("midrst carry", 32'(carry_out), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst valid", 32'(res_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    run_op("after reset", 2'd1, 2'd2, 5'd0, 8'd17, 32'h8765_4321, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
